// File: rtl/order_n_pipe.sv
`default_nettype none
// ============================================================================
// Module   : order_n_pipe
// Brief    : Three-stage pipelined NUM-input sorter with valid/ready flow
//            control, per-vector ascending/descending mode, stable ties and
//            source-index outputs.
// Revision : 1.0 - initial release
// ============================================================================
module order_n_pipe #(
  parameter int DSIZE = 8,
  parameter int NUM   = 4,
  parameter int IDXW  = $clog2(NUM)
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  descend,
  input  logic [NUM*DSIZE-1:0]  indata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM*DSIZE-1:0]  outdata,
  output logic [NUM*IDXW-1:0]   outidx
);

  // Stage 1: captured input vector
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_desc_q,  s1_desc_d;
  logic [NUM*DSIZE-1:0] s1_data_q,  s1_data_d;

  // Stage 2: data plus per-element rank
  logic                 s2_valid_q, s2_valid_d;
  logic [NUM*DSIZE-1:0] s2_data_q,  s2_data_d;
  logic [NUM*IDXW-1:0]  s2_rank_q,  s2_rank_d;

  // Stage 3: scattered (sorted) output
  logic                 out_valid_q, out_valid_d;
  logic [NUM*DSIZE-1:0] outdata_q,   outdata_d;
  logic [NUM*IDXW-1:0]  outidx_q,    outidx_d;

  // Pairwise precedence and derived ranks for the stage-1 vector
  logic [NUM-1:0]       prec [NUM];   // prec[i][j]: element i sorts before j
  logic [IDXW-1:0]      rank_acc;
  logic [NUM*IDXW-1:0]  rank_w;

  logic en;

  // The whole pipe moves together; it only stalls on an unaccepted output.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en && rst_n;

  assign out_valid = out_valid_q;
  assign outdata   = outdata_q;
  assign outidx    = outidx_q;

  // One comparator per unordered pair; the lower index wins ties in both modes.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      prec[i] = '0;
    end
    for (int i = 0; i < NUM; i++) begin
      for (int j = i + 1; j < NUM; j++) begin
        prec[i][j] = s1_desc_q ? (s1_data_q[i*DSIZE +: DSIZE] >= s1_data_q[j*DSIZE +: DSIZE])
                               : (s1_data_q[i*DSIZE +: DSIZE] <= s1_data_q[j*DSIZE +: DSIZE]);
        prec[j][i] = !prec[i][j];
      end
    end
  end

  // Rank of element i = how many other elements sort ahead of it.
  always_comb begin
    rank_w   = '0;
    rank_acc = '0;
    for (int i = 0; i < NUM; i++) begin
      rank_acc = '0;
      for (int j = 0; j < NUM; j++) begin
        if ((j != i) && prec[j][i]) begin
          rank_acc = rank_acc + IDXW'(1);
        end
      end
      rank_w[i*IDXW +: IDXW] = rank_acc;
    end
  end

  // Next-state for all stages: hold by default, advance together when enabled.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_desc_d   = s1_desc_q;
    s1_data_d   = s1_data_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_rank_d   = s2_rank_q;
    out_valid_d = out_valid_q;
    outdata_d   = outdata_q;
    outidx_d    = outidx_q;
    if (en) begin
      s1_valid_d  = in_valid;
      s1_desc_d   = descend;
      s1_data_d   = indata;
      s2_valid_d  = s1_valid_q;
      s2_data_d   = s1_data_q;
      s2_rank_d   = rank_w;
      out_valid_d = s2_valid_q;
      // Ranks are a permutation, so every output slot is written exactly once.
      // Bubbles leave the previous result in place.
      if (s2_valid_q) begin
        for (int i = 0; i < NUM; i++) begin
          outdata_d[int'(s2_rank_q[i*IDXW +: IDXW])*DSIZE +: DSIZE] = s2_data_q[i*DSIZE +: DSIZE];
          outidx_d[int'(s2_rank_q[i*IDXW +: IDXW])*IDXW +: IDXW]    = IDXW'(i);
        end
      end
    end
  end

  // Pipeline registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_desc_q   <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_rank_q   <= '0;
      out_valid_q <= 1'b0;
      outdata_q   <= '0;
      outidx_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_desc_q   <= s1_desc_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_rank_q   <= s2_rank_d;
      out_valid_q <= out_valid_d;
      outdata_q   <= outdata_d;
      outidx_q    <= outidx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_order_n_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_order_n_pipe
// Brief    : Self-checking bench for order_n_pipe (NUM=4, DSIZE=8) using a
//            stable insertion-sort reference and an in-order expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_order_n_pipe;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic            clock;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            descend;
  logic [N*W-1:0]  indata;
  logic            out_valid;
  logic            out_ready;
  logic [N*W-1:0]  outdata;
  logic [N*IW-1:0] outidx;

  order_n_pipe #(.DSIZE(W), .NUM(N)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .descend   (descend),
    .indata    (indata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outdata   (outdata),
    .outidx    (outidx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [N*W-1:0]  d;
    logic [N*IW-1:0] x;
    int              acc;
    bit              seen;
  } exp_t;

  exp_t            q[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              delivered = 0;
  bit              chk_lat = 1'b1;
  bit              last_acc_in;
  logic [N*W-1:0]  last_d = '0;
  logic [N*IW-1:0] last_x = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: stable insertion sort by value, direction chosen per vector.
  function automatic void model(input logic [N*W-1:0] v, input logic d,
                                output logic [N*W-1:0] od, output logic [N*IW-1:0] ox);
    logic [W-1:0] a[N];
    int ord[N];
    int k;
    int j;
    for (int i = 0; i < N; i++) begin
      a[i]   = v[i*W +: W];
      ord[i] = i;
    end
    for (int i = 1; i < N; i++) begin
      k = ord[i];
      j = i - 1;
      while (j >= 0 && (d ? (a[k] > a[ord[j]]) : (a[k] < a[ord[j]]))) begin
        ord[j+1] = ord[j];
        j--;
      end
      ord[j+1] = k;
    end
    od = '0;
    ox = '0;
    for (int s = 0; s < N; s++) begin
      od[s*W +: W]   = a[ord[s]];
      ox[s*IW +: IW] = IW'(ord[s]);
    end
  endfunction

  // One clock: inputs were driven 1ns after the previous edge.
  task automatic cycle();
    bit acc_out;
    logic [N*W-1:0] vin;
    logic din;
    logic rin;
    exp_t e;
    #1;
    chk("in_ready", in_ready, rst_n && (!out_valid || out_ready));
    last_acc_in = (in_valid && in_ready) === 1'b1;
    acc_out     = (out_valid && out_ready) === 1'b1;
    vin = indata;
    din = descend;
    rin = rst_n;
    @(posedge clock);
    cyc++;
    #1;
    if (!rin) begin
      q.delete();
      last_d = '0;
      last_x = '0;
    end else begin
      if (acc_out && q.size() > 0) begin
        void'(q.pop_front());
        delivered++;
      end
      if (last_acc_in) begin
        model(vin, din, e.d, e.x);
        e.acc  = cyc;
        e.seen = 1'b0;
        q.push_back(e);
      end
    end
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", out_valid, 1'b0);
      end else begin
        chk("outdata", outdata, q[0].d);
        chk("outidx", outidx, q[0].x);
        if (chk_lat && !q[0].seen) chk("latency", cyc, q[0].acc + 2);
        q[0].seen = 1'b1;
      end
      last_d = outdata;
      last_x = outidx;
    end else begin
      chk("hold_data", outdata, last_d);
      chk("hold_idx", outidx, last_x);
      if (chk_lat && q.size() > 0 && cyc >= q[0].acc + 2) chk("missing_valid", out_valid, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_directed(input logic [N*W-1:0] v, input logic d,
                               input logic [N*W-1:0] ed, input logic [N*IW-1:0] ex);
    in_valid = 1'b1;
    indata   = v;
    descend  = d;
    cycle();
    idle(4);
    chk("dir_data", outdata, ed);
    chk("dir_idx", outidx, ex);
  endtask

  initial begin
    int sent;
    int t;
    int base;
    logic [N*W-1:0] bpv[5];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    descend   = 1'b0;
    indata    = '0;
    out_ready = 1'b1;
    idle(2);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", outdata, '0);
    chk("rst_idx", outidx, '0);
    rst_n = 1'b1;
    idle(1);

    // Directed vectors; elements packed as {e3,e2,e1,e0}, slot 0 at LSB.
    send_directed({8'd7, 8'd1, 8'd9, 8'd3}, 1'b1, {8'd1, 8'd3, 8'd7, 8'd9}, {2'd2, 2'd0, 2'd3, 2'd1});
    send_directed({8'd2, 8'd5, 8'd2, 8'd5}, 1'b0, {8'd5, 8'd5, 8'd2, 8'd2}, {2'd2, 2'd0, 2'd3, 2'd1});
    send_directed({8'd2, 8'd5, 8'd2, 8'd5}, 1'b1, {8'd2, 8'd2, 8'd5, 8'd5}, {2'd3, 2'd1, 2'd2, 2'd0});
    send_directed({4{8'hFF}}, 1'b0, {4{8'hFF}}, {2'd3, 2'd2, 2'd1, 2'd0});
    send_directed({8'd255, 8'd0, 8'd255, 8'd0}, 1'b0, {8'd255, 8'd255, 8'd0, 8'd0}, {2'd3, 2'd1, 2'd2, 2'd0});

    // Streaming: 10 back-to-back random vectors, alternating direction.
    base = delivered;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      indata   = (k % 3 == 0) ? {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                                 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))}
                              : $urandom;
      descend  = k[0];
      cycle();
    end
    idle(4);
    chk("stream_delivered", delivered - base, 10);

    // Backpressure: out_ready low for 4 cycles mid-stream.
    chk_lat = 1'b0;
    for (int k = 0; k < 5; k++) bpv[k] = $urandom;
    sent = 0;
    t    = 0;
    base = delivered;
    while ((sent < 5 || t < 8) && t < 40) begin
      out_ready = !(t >= 2 && t < 6);
      in_valid  = (sent < 5);
      if (sent < 5) begin
        indata  = bpv[sent];
        descend = sent[0];
      end
      cycle();
      if (last_acc_in) sent++;
      t++;
    end
    chk("bp_sent", sent, 5);
    out_ready = 1'b1;
    idle(6);
    chk("bp_delivered", delivered - base, 5);

    // Random traffic with random backpressure; producer holds until accepted.
    in_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!in_valid || last_acc_in) begin
        in_valid = 1'($urandom_range(0, 1));
        indata   = $urandom;
        descend  = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    out_ready = 1'b1;
    idle(6);
    chk("rand_drained", q.size(), 0);

    // Reset mid-flight: two vectors in the pipe are discarded.
    chk_lat  = 1'b1;
    in_valid = 1'b1;
    indata   = {8'd4, 8'd3, 8'd2, 8'd1};
    descend  = 1'b1;
    cycle();
    indata   = {8'd10, 8'd40, 8'd30, 8'd20};
    descend  = 1'b0;
    cycle();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cycle();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", outdata, '0);
    chk("midrst_idx", outidx, '0);
    rst_n = 1'b1;
    idle(3);
    chk("post_rst_valid", out_valid, 1'b0);
    send_directed({8'd7, 8'd1, 8'd9, 8'd3}, 1'b0, {8'd9, 8'd7, 8'd3, 8'd1}, {2'd1, 2'd3, 2'd0, 2'd2});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
